siphash_tenant_arbiter: RTL and testbench
=========================================

# siphash_tenant_arbiter

Round-robin scheduler that shares one `siphash_core` among `NT` tenant ports on the multi-tenant fabric. It grants one tenant at a time and sequences the core through initialize → compress (per word) → finalize. It captures the 64-bit tag, completes the core's `resp_rec` handshake and returns the tag to the granted tenant. The block sits between the tenant-facing shell and the core; every core control input is driven only from here.

## Interface
- `NT`, 4: number of tenant ports, 2..8.
- `MAX_WORDS`, 16: per-job compress word limit (anti-hogging quantum).
- `C_ROUNDS`, 2: driven on `core_compression_rounds`; must be ≥1.
- `D_ROUNDS`, 4: driven on `core_final_rounds`; must be ≥1.
- `clk`  in  1  sole clock, all logic rising edge.
- `reset`  in  1  synchronous, active-high; the top level ties core `reset_n = ~reset`.
- `req`  in  NT  tenant i requests a job; sampled only in IDLE.
- `key_flat`  in  NT*128  tenant i key at [128i+127:128i]; k0 is the low 64 bits.
- `mi_flat`  in  NT*64  tenant i message word, already padded/length-encoded by the tenant.
- `mi_valid`  in  NT  word valid.
- `mi_last`  in  NT  qualifies the final word of the job.
- `mi_ready`  out  NT  one-hot; word accepted when valid && ready.
- `grant`  out  NT  one-hot owner, held from INIT through DRAIN.
- `res_valid`  out  NT  one-cycle one-hot pulse.
- `res_word`  out  64  tag, held until the next `res_valid`.
- `res_err`  out  1  qualifies `res_valid`: job truncated at `MAX_WORDS`.
- `core_initalize`, `core_compress`, `core_finalize`, `core_resp_rec`  out  1 each  core controls.
- `core_long`  out  1  constant 0 (64-bit tag only).
- `core_key`  out  128  muxed key of the granted tenant.
- `core_mi`  out  64  registered word.
- `core_compression_rounds`, `core_final_rounds`  out  4 each  from the parameters.
- `core_word`  in  64  core tag.
- `core_word_valid`  in  1  core tag valid.
- `core_state`  in  3  core control state (0 = IDLE, 4 = FINAL0_END).

## Operation
- States: IDLE, INIT, LOAD, COMP, COMP_WAIT, FIN, FIN_WAIT, RESP, DRAIN.
- IDLE: if `req != 0`, pick the first set bit at or after `rr_ptr` (wrapping), latch index `g`, go to INIT.
- INIT: `core_initalize=1` for one cycle; clears the core's stale `word_valid`; word counter := 0.
- LOAD: `mi_ready[g]=1`. On accept, latch `core_mi` and the last flag, increment the counter, go to COMP.
- COMP: `core_compress=1` for one cycle, then COMP_WAIT.
- COMP_WAIT: wait until `core_state==0`.
  - If last, go to FIN.
  - Else if counter == `MAX_WORDS`, set the err flag and go to FIN.
  - Else go to LOAD.
- FIN: `core_finalize=1` for one cycle, then FIN_WAIT.
- FIN_WAIT: when `core_word_valid && core_state==4`, capture `core_word` into `res_word` and go to RESP.
- RESP: `core_resp_rec=1` and `res_valid[g]=1` for one cycle; `res_err` = err flag; go to DRAIN.
- DRAIN: wait `core_state==0`, then `rr_ptr := (g+1) mod NT`, clear the err flag, drop `grant`, go to IDLE.
- Core inputs `key`/`mi` stay stable from INIT/COMP until the next change.
- At most one of `core_initalize`/`core_compress`/`core_finalize` is high per cycle.
- Simultaneous requests: round-robin order. A tenant dropping `req` mid-job is ignored; the job completes.
- A truncated job still produces a tag. Words not consumed stay unaccepted; the tenant must drop them.
- `mi_valid` on a non-granted port is never accepted.
- Reset mid-job: FSM → IDLE, `rr_ptr` → 0, all outputs → 0, no `res_valid`.

## Timing
- Reset values:
  - `grant`, `mi_ready`, `res_valid`, `res_err`, all core strobes, `core_mi` = 0.
  - `res_word` = 0.
  - `core_key` = 0 (no grant).
- Grant latency: `req` seen in IDLE → `grant` high on the next cycle (INIT).
- Per word: accept → COMP (1) → COMP_WAIT for `C_ROUNDS`+1 cycles of core busy.
- Finalize: FIN (1) → `D_ROUNDS` core rounds → FINAL0_END → FIN_WAIT exits the cycle after `word_valid` rises.
- Back-to-back jobs: one IDLE cycle between DRAIN exit and the next INIT.

## Test plan
- Single job, tenant 0: key k0=0x0706050403020100, k1=0x0F0E0D0C0B0A0908; one word 0x0 with last → `res_valid[0]`, `res_word`=0x726FDB47DD0E0E31, `res_err`=0.
- Tenants 1 and 3 request together with `rr_ptr`=0 → tenant 1 served, then tenant 3; next simultaneous 0 and 1 → 0 first.
- `MAX_WORDS`=2, tenant sends 3 words without last → two compresses, `res_err`=1, third word never accepted.
- Stalled `mi_valid` for 10 cycles in LOAD → no core strobes; the job resumes correctly.
- Reset asserted during COMP_WAIT → all outputs 0 next cycle; a fresh job afterwards gives the correct tag.
- Strobe check across all jobs: strobes mutually exclusive, `core_resp_rec` exactly once per job, `grant` stable from INIT to DRAIN.

Source files
------------

// File: rtl/siphash_tenant_arbiter.sv
// siphash_tenant_arbiter
//
// Round-robin scheduler that shares one siphash_core among NT tenant ports.
// One tenant is granted at a time. The core is sequenced through
// initialize -> compress (one per message word) -> finalize. The 64-bit
// tag is captured, the core's resp_rec handshake is completed, and the tag
// is returned to the granted tenant.
//
// Ports
//   clk, reset                 : sole clock (rising edge), synchronous active-high reset
//   req[NT]                    : per-tenant job request, sampled only while idle
//   key_flat[NT*128]           : tenant i key at [128i+127:128i], k0 in the low 64 bits
//   mi_flat[NT*64]             : tenant i message word (already padded by the tenant)
//   mi_valid/mi_last[NT]       : word valid / final word of the job
//   mi_ready[NT]               : one-hot, word accepted when valid && ready
//   grant[NT]                  : one-hot owner, held from INIT through DRAIN
//   res_valid[NT]              : one-cycle one-hot tag pulse
//   res_word[64], res_err      : tag (held until the next pulse), truncation flag
//   core_*                     : siphash_core control/data, driven only from here
module siphash_tenant_arbiter #(
    parameter int NT        = 4,
    parameter int MAX_WORDS = 16,
    parameter int C_ROUNDS  = 2,
    parameter int D_ROUNDS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NT-1:0]     req,
    input  logic [NT*128-1:0] key_flat,
    input  logic [NT*64-1:0]  mi_flat,
    input  logic [NT-1:0]     mi_valid,
    input  logic [NT-1:0]     mi_last,
    output logic [NT-1:0]     mi_ready,
    output logic [NT-1:0]     grant,
    output logic [NT-1:0]     res_valid,
    output logic [63:0]       res_word,
    output logic              res_err,
    output logic              core_initalize,
    output logic              core_compress,
    output logic              core_finalize,
    output logic              core_resp_rec,
    output logic              core_long,
    output logic [127:0]      core_key,
    output logic [63:0]       core_mi,
    output logic [3:0]        core_compression_rounds,
    output logic [3:0]        core_final_rounds,
    input  logic [63:0]       core_word,
    input  logic              core_word_valid,
    input  logic [2:0]        core_state
);

    localparam int GW = $clog2(NT);
    localparam int CW = $clog2(MAX_WORDS + 1);

    localparam logic [2:0]    CORE_IDLE       = 3'd0;
    localparam logic [2:0]    CORE_FINAL0_END = 3'd4;
    localparam logic [CW-1:0] WORD_LIMIT      = CW'(MAX_WORDS);
    localparam logic [GW-1:0] LAST_TENANT     = GW'(NT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_COMP,
        S_COMP_WAIT,
        S_FIN,
        S_FIN_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   g;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   next_ptr;
    logic [CW-1:0]   word_cnt;
    logic            last_flag;
    logic            err_flag;
    logic [NT-1:0]   g_onehot;
    logic            accept;
    logic            core_idle;

    // First requesting tenant at or after ptr, wrapping around.
    function automatic logic [GW-1:0] rr_pick(input logic [NT-1:0] r, input logic [GW-1:0] ptr);
        logic [GW-1:0] sel;
        logic          found;
        int            idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NT; k++) begin
            idx = (int'(ptr) + k) % NT;
            if (!found && r[idx]) begin
                sel   = GW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick      = rr_pick(req, rr_ptr);
    assign next_ptr  = (g == LAST_TENANT) ? '0 : g + 1'b1;
    assign g_onehot  = NT'(1) << g;
    assign accept    = (state == S_LOAD) && mi_valid[g];
    assign core_idle = (core_state == CORE_IDLE);

    assign core_long               = 1'b0;
    assign core_compression_rounds = 4'(C_ROUNDS);
    assign core_final_rounds       = 4'(D_ROUNDS);

    // State register and job datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            g         <= '0;
            rr_ptr    <= '0;
            word_cnt  <= '0;
            last_flag <= 1'b0;
            err_flag  <= 1'b0;
            core_mi   <= '0;
            core_key  <= '0;
            res_word  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        g        <= pick;
                        // Key is latched at grant so the core sees it stable for the whole job.
                        core_key <= key_flat[pick*128 +: 128];
                    end
                end
                S_INIT: begin
                    word_cnt  <= '0;
                    err_flag  <= 1'b0;
                    last_flag <= 1'b0;
                end
                S_LOAD: begin
                    if (accept) begin
                        core_mi   <= mi_flat[g*64 +: 64];
                        last_flag <= mi_last[g];
                        word_cnt  <= word_cnt + 1'b1;
                    end
                end
                S_COMP_WAIT: begin
                    // A final word arriving exactly at the limit is not a truncation.
                    if (core_idle && !last_flag && word_cnt == WORD_LIMIT) begin
                        err_flag <= 1'b1;
                    end
                end
                S_FIN_WAIT: begin
                    if (core_word_valid && core_state == CORE_FINAL0_END) begin
                        res_word <= core_word;
                    end
                end
                S_DRAIN: begin
                    if (core_idle) begin
                        rr_ptr   <= next_ptr;
                        err_flag <= 1'b0;
                        core_key <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and Moore-decoded outputs.
    always_comb begin
        state_nxt      = state;
        grant          = '0;
        mi_ready       = '0;
        res_valid      = '0;
        res_err        = 1'b0;
        core_initalize = 1'b0;
        core_compress  = 1'b0;
        core_finalize  = 1'b0;
        core_resp_rec  = 1'b0;

        if (state != S_IDLE) begin
            grant = g_onehot;
        end

        case (state)
            S_IDLE: begin
                if (|req) state_nxt = S_INIT;
            end
            S_INIT: begin
                core_initalize = 1'b1;
                state_nxt      = S_LOAD;
            end
            S_LOAD: begin
                mi_ready = g_onehot;
                if (accept) state_nxt = S_COMP;
            end
            S_COMP: begin
                core_compress = 1'b1;
                state_nxt     = S_COMP_WAIT;
            end
            S_COMP_WAIT: begin
                if (core_idle) begin
                    if (last_flag || word_cnt == WORD_LIMIT) state_nxt = S_FIN;
                    else                                     state_nxt = S_LOAD;
                end
            end
            S_FIN: begin
                core_finalize = 1'b1;
                state_nxt     = S_FIN_WAIT;
            end
            S_FIN_WAIT: begin
                // word_valid alone may be stale; the core state confirms the fresh tag.
                if (core_word_valid && core_state == CORE_FINAL0_END) state_nxt = S_RESP;
            end
            S_RESP: begin
                core_resp_rec = 1'b1;
                res_valid     = g_onehot;
                res_err       = err_flag;
                state_nxt     = S_DRAIN;
            end
            S_DRAIN: begin
                if (core_idle) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_siphash_tenant_arbiter.sv
// Testbench for siphash_tenant_arbiter with a behavioural siphash_core model.
module tb_siphash_tenant_arbiter;

    localparam int NT   = 4;
    localparam int MAXW = 2;
    localparam int CR   = 2;
    localparam int DR   = 4;
    localparam logic [63:0] STD_TAG = 64'h726FDB47DD0E0E31;

    logic               clk = 1'b0;
    logic               reset;
    logic [NT-1:0]      req;
    logic [NT*128-1:0]  key_flat;
    logic [NT*64-1:0]   mi_flat;
    logic [NT-1:0]      mi_valid;
    logic [NT-1:0]      mi_last;
    logic [NT-1:0]      mi_ready;
    logic [NT-1:0]      grant;
    logic [NT-1:0]      res_valid;
    logic [63:0]        res_word;
    logic               res_err;
    logic               core_initalize;
    logic               core_compress;
    logic               core_finalize;
    logic               core_resp_rec;
    logic               core_long;
    logic [127:0]       core_key;
    logic [63:0]        core_mi;
    logic [3:0]         core_compression_rounds;
    logic [3:0]         core_final_rounds;
    logic [63:0]        core_word;
    logic               core_word_valid;
    logic [2:0]         core_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    siphash_tenant_arbiter #(
        .NT(NT), .MAX_WORDS(MAXW), .C_ROUNDS(CR), .D_ROUNDS(DR)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .key_flat(key_flat), .mi_flat(mi_flat),
        .mi_valid(mi_valid), .mi_last(mi_last), .mi_ready(mi_ready), .grant(grant),
        .res_valid(res_valid), .res_word(res_word), .res_err(res_err),
        .core_initalize(core_initalize), .core_compress(core_compress),
        .core_finalize(core_finalize), .core_resp_rec(core_resp_rec), .core_long(core_long),
        .core_key(core_key), .core_mi(core_mi),
        .core_compression_rounds(core_compression_rounds), .core_final_rounds(core_final_rounds),
        .core_word(core_word), .core_word_valid(core_word_valid), .core_state(core_state)
    );

    // ---------------- SipHash reference ----------------
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [255:0] sip_init(input logic [127:0] k);
        logic [63:0] k0;
        logic [63:0] k1;
        k0 = k[63:0];
        k1 = k[127:64];
        return {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
                k1 ^ 64'h646f72616e646f6d, k0 ^ 64'h736f6d6570736575};
    endfunction

    function automatic logic [255:0] sipround(input logic [255:0] v);
        logic [63:0] v0, v1, v2, v3;
        {v3, v2, v1, v0} = v;
        v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
        v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
        v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
        v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
        return {v3, v2, v1, v0};
    endfunction

    function automatic logic [63:0] ref_tag(input logic [127:0] k, input logic [63:0] w0,
                                            input logic [63:0] w1, input int n);
        logic [255:0] v;
        logic [63:0]  m;
        v = sip_init(k);
        for (int w = 0; w < n; w++) begin
            m = (w == 0) ? w0 : w1;
            v[255:192] = v[255:192] ^ m;
            for (int r = 0; r < CR; r++) v = sipround(v);
            v[63:0] = v[63:0] ^ m;
        end
        v[191:128] = v[191:128] ^ 64'hff;
        for (int r = 0; r < DR; r++) v = sipround(v);
        return v[63:0] ^ v[127:64] ^ v[191:128] ^ v[255:192];
    endfunction

    // ---------------- behavioural siphash_core ----------------
    logic [255:0] cv;
    logic [3:0]   crc;
    logic [255:0] cv_next;
    assign cv_next = sipround(cv);

    always_ff @(posedge clk) begin
        if (reset) begin
            core_state      <= 3'd0;
            core_word_valid <= 1'b0;
            core_word       <= '0;
            cv              <= '0;
            crc             <= '0;
        end else begin
            case (core_state)
                3'd0: begin
                    if (core_initalize) begin
                        cv              <= sip_init(core_key);
                        core_word_valid <= 1'b0;
                    end else if (core_compress) begin
                        cv         <= cv ^ {core_mi, 192'b0};
                        crc        <= core_compression_rounds;
                        core_state <= 3'd1;
                    end else if (core_finalize) begin
                        cv         <= cv ^ {64'b0, 64'hff, 128'b0};
                        crc        <= core_final_rounds;
                        core_state <= 3'd3;
                    end
                end
                3'd1: begin
                    cv  <= cv_next;
                    crc <= crc - 4'd1;
                    if (crc == 4'd1) core_state <= 3'd2;
                end
                3'd2: begin
                    cv         <= cv ^ {192'b0, core_mi};
                    core_state <= 3'd0;
                end
                3'd3: begin
                    cv  <= cv_next;
                    crc <= crc - 4'd1;
                    if (crc == 4'd1) begin
                        core_word       <= cv_next[63:0] ^ cv_next[127:64] ^ cv_next[191:128] ^ cv_next[255:192];
                        core_word_valid <= 1'b1;
                        core_state      <= 3'd4;
                    end
                end
                3'd4: if (core_resp_rec) core_state <= 3'd0;
                default: core_state <= 3'd0;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] tkey(input int i, input int seed);
        if (seed == 0) return {64'h0F0E0D0C0B0A0908, 64'h0706050403020100};
        return {32'(seed), 32'(i), 64'hDEAD_BEEF_0000_0000 | 64'(seed * 16 + i)};
    endfunction

    function automatic logic [63:0] tword(input int i, input int w, input int seed);
        if (seed == 0) return 64'h0;
        return 64'h0123_4567_89AB_CDEF ^ {32'(seed), 16'(i), 16'(w)};
    endfunction

    typedef struct {
        logic [NT-1:0] mask;
        int            nw;
        bit            last;
        int            stall;
        int            exp_n;
        int            exp0;
        int            exp1;
        bit            err;
        int            seed;
    } vec_t;

    function automatic logic [63:0] exp_tag(input int i, input vec_t v);
        int n;
        if (v.seed == 0) return STD_TAG;
        n = (v.nw < MAXW) ? v.nw : MAXW;
        return ref_tag(tkey(i, v.seed), tword(i, 0, v.seed), tword(i, 1, v.seed), n);
    endfunction

    task automatic run_round(input int vi, input vec_t v);
        int            served[$];
        logic [63:0]   tags[$];
        logic          errs[$];
        int            widx[NT];
        int            acc[NT];
        logic [NT-1:0] done_mask;
        logic [NT-1:0] prev_grant;
        int ncomp, nresp, excl_bad, grant_bad, stall_bad, stall_left, pend, cyc, first_g, gap, exp_acc;
        bit done;
        string pfx;
        pfx = $sformatf("v%0d", vi);
        ncomp = 0; nresp = 0; excl_bad = 0; grant_bad = 0; stall_bad = 0;
        stall_left = v.stall; pend = -1; cyc = 0; first_g = -1; gap = 0; done = 0;
        done_mask = '0; prev_grant = '0;
        for (int i = 0; i < NT; i++) begin
            widx[i] = 0;
            acc[i]  = 0;
            if (v.mask[i]) key_flat[i*128 +: 128] = tkey(i, v.seed);
        end
        req = v.mask;
        while (cyc < 2000 && !done) begin
            @(negedge clk);
            cyc++;
            if (pend >= 0) begin
                widx[pend]++;
                acc[pend]++;
                pend = -1;
            end
            if ($countones({core_initalize, core_compress, core_finalize}) > 1) excl_bad++;
            ncomp += int'(core_compress);
            nresp += int'(core_resp_rec);
            if ($countones(grant) > 1) grant_bad++;
            if (prev_grant != 0 && grant != 0 && grant != prev_grant) grant_bad++;
            if (grant != 0 && first_g < 0) first_g = cyc;
            if (grant == 0 && first_g >= 0) gap++;
            if (grant != 0 && gap > 0) begin
                if (gap != 1) grant_bad++;
                gap = 0;
            end
            prev_grant = grant;
            for (int i = 0; i < NT; i++) begin
                if (res_valid[i]) begin
                    served.push_back(i);
                    tags.push_back(res_word);
                    errs.push_back(res_err);
                    req[i]       = 1'b0;
                    done_mask[i] = 1'b1;
                end
            end
            for (int i = 0; i < NT; i++) begin
                mi_valid[i] = 1'b0;
                mi_last[i]  = 1'b0;
                if (v.mask[i] && !done_mask[i] && widx[i] < v.nw) begin
                    mi_flat[i*64 +: 64] = tword(i, widx[i], v.seed);
                    mi_last[i] = v.last && (widx[i] == v.nw - 1);
                    if (mi_ready[i] && stall_left > 0) begin
                        stall_left--;
                        if (core_initalize || core_compress || core_finalize || core_resp_rec) stall_bad++;
                    end else begin
                        mi_valid[i] = 1'b1;
                    end
                end
                if (mi_valid[i] && mi_ready[i]) pend = i;
            end
            if (done_mask == v.mask && grant == 0) done = 1;
        end
        mi_valid = '0;
        mi_last  = '0;
        req      = '0;
        chk({pfx, " timeout"}, 128'(done), 128'(1));
        chk({pfx, " grant latency"}, 128'(first_g), 128'(1));
        chk({pfx, " jobs served"}, 128'(served.size()), 128'(v.exp_n));
        if (served.size() > 0) chk({pfx, " first tenant"}, 128'(served[0]), 128'(v.exp0));
        if (served.size() > 1) chk({pfx, " second tenant"}, 128'(served[1]), 128'(v.exp1));
        for (int s = 0; s < served.size(); s++) begin
            chk($sformatf("%s tag t%0d", pfx, served[s]), 128'(tags[s]), 128'(exp_tag(served[s], v)));
            chk($sformatf("%s err t%0d", pfx, served[s]), 128'(errs[s]), 128'(v.err));
        end
        exp_acc = (v.nw < MAXW) ? v.nw : MAXW;
        for (int i = 0; i < NT; i++) begin
            chk($sformatf("%s accepted t%0d", pfx, i), 128'(acc[i]), v.mask[i] ? 128'(exp_acc) : 128'(0));
        end
        chk({pfx, " compress count"}, 128'(ncomp), 128'($countones(v.mask) * exp_acc));
        chk({pfx, " resp_rec count"}, 128'(nresp), 128'(v.exp_n));
        chk({pfx, " strobe exclusive"}, 128'(excl_bad), 128'(0));
        chk({pfx, " grant stability"}, 128'(grant_bad), 128'(0));
        if (v.stall > 0) chk({pfx, " stall strobes"}, 128'(stall_bad), 128'(0));
        if (tags.size() > 0) chk({pfx, " res_word held"}, 128'(res_word), 128'(tags[tags.size()-1]));
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, " grant"}, 128'(grant), 128'(0));
        chk({pfx, " mi_ready"}, 128'(mi_ready), 128'(0));
        chk({pfx, " res_valid/err"}, 128'({res_valid, res_err}), 128'(0));
        chk({pfx, " strobes"}, 128'({core_initalize, core_compress, core_finalize, core_resp_rec, core_long}), 128'(0));
        chk({pfx, " core_mi"}, 128'(core_mi), 128'(0));
        chk({pfx, " core_key"}, 128'(core_key), 128'(0));
        chk({pfx, " res_word"}, 128'(res_word), 128'(0));
    endtask

    vec_t vecs[6];
    vec_t post_rst;

    initial begin
        int n;
        bit ok;
        // mask, nw, last, stall, exp_n, exp0, exp1, err, seed
        vecs[0] = '{mask: 4'b1010, nw: 2, last: 1'b1, stall: 0,  exp_n: 2, exp0: 1, exp1: 3,  err: 1'b0, seed: 1};
        vecs[1] = '{mask: 4'b0011, nw: 1, last: 1'b1, stall: 0,  exp_n: 2, exp0: 0, exp1: 1,  err: 1'b0, seed: 2};
        vecs[2] = '{mask: 4'b0001, nw: 1, last: 1'b1, stall: 0,  exp_n: 1, exp0: 0, exp1: -1, err: 1'b0, seed: 0};
        vecs[3] = '{mask: 4'b0100, nw: 3, last: 1'b0, stall: 0,  exp_n: 1, exp0: 2, exp1: -1, err: 1'b1, seed: 3};
        vecs[4] = '{mask: 4'b1000, nw: 2, last: 1'b1, stall: 10, exp_n: 1, exp0: 3, exp1: -1, err: 1'b0, seed: 4};
        vecs[5] = '{mask: 4'b1001, nw: 1, last: 1'b1, stall: 0,  exp_n: 2, exp0: 0, exp1: 3,  err: 1'b0, seed: 5};
        post_rst = '{mask: 4'b0011, nw: 1, last: 1'b1, stall: 0, exp_n: 2, exp0: 0, exp1: 1,  err: 1'b0, seed: 0};

        reset = 1'b1; req = '0; key_flat = '0; mi_flat = '0; mi_valid = '0; mi_last = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset rounds", 128'({core_compression_rounds, core_final_rounds}), 128'({4'(CR), 4'(DR)}));
        reset = 1'b0;

        for (int vi = 0; vi < 6; vi++) run_round(vi, vecs[vi]);

        // Reset while the core is busy compressing.
        key_flat[2*128 +: 128] = tkey(2, 6);
        mi_flat[2*64 +: 64]    = tword(2, 0, 6);
        req = 4'b0100;
        n = 0; ok = 0;
        while (n < 50 && !ok) begin
            @(negedge clk); n++;
            if (mi_ready[2]) ok = 1;
        end
        chk("rst job ready", 128'(ok), 128'(1));
        mi_valid[2] = 1'b1;
        @(negedge clk);
        mi_valid[2] = 1'b0;
        n = 0; ok = 0;
        while (n < 50 && !ok) begin
            @(negedge clk); n++;
            if (core_state == 3'd1) ok = 1;
        end
        chk("rst job busy", 128'(ok), 128'(1));
        chk("rst job core_mi", 128'(core_mi), 128'(tword(2, 0, 6)));
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk_all_zero("midjob reset");
        reset = 1'b0;
        run_round(6, post_rst);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
